// File: rtl/axi_sync_channel_buffer_if.sv
// AXI4 five-channel bundle with opaque packed payloads; master drives AW/W/AR and takes B/R.
interface axi_sync_channel_buffer_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int AX_PW = ID_W + ADDR_W + 8 + 3 + 2;
  localparam int W_PW  = DATA_W + DATA_W / 8 + 1;
  localparam int B_PW  = ID_W + 2;
  localparam int R_PW  = ID_W + DATA_W + 2 + 1;

  logic             aw_valid;
  logic             aw_ready;
  logic [AX_PW-1:0] aw_payload;
  logic             w_valid;
  logic             w_ready;
  logic [W_PW-1:0]  w_payload;
  logic             b_valid;
  logic             b_ready;
  logic [B_PW-1:0]  b_payload;
  logic             ar_valid;
  logic             ar_ready;
  logic [AX_PW-1:0] ar_payload;
  logic             r_valid;
  logic             r_ready;
  logic [R_PW-1:0]  r_payload;

  modport master (
    output aw_valid, aw_payload, w_valid, w_payload, b_ready,
    output ar_valid, ar_payload, r_ready,
    input  aw_ready, w_ready, b_valid, b_payload, ar_ready, r_valid, r_payload
  );

  modport slave (
    input  aw_valid, aw_payload, w_valid, w_payload, b_ready,
    input  ar_valid, ar_payload, r_ready,
    output aw_ready, w_ready, b_valid, b_payload, ar_ready, r_valid, r_payload
  );
endinterface

// File: rtl/axi_sync_channel_buffer.sv
// Single-clock AXI4 channel buffer: one FWFT FIFO per channel plus AW/AR outstanding limiters.
// Registered ready/empty state keeps S-side READY and M-side VALID glitch-free and reset-low.
module axi_sync_channel_buffer_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic                ready_reg, empty_reg, push, pop, full_next;

  assign push      = in_valid && ready_reg;
  assign pop       = out_valid && out_ready;
  assign in_ready  = ready_reg;
  assign out_valid = !empty_reg;
  assign empty     = empty_reg;
  assign out_data  = mem[rd_ptr_reg[DEPTH_LOG2-1:0]];

  assign wr_ptr_next = wr_ptr_reg + {{DEPTH_LOG2{1'b0}}, push};
  assign rd_ptr_next = rd_ptr_reg + {{DEPTH_LOG2{1'b0}}, pop};
  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_next = (wr_ptr_next[DEPTH_LOG2] != rd_ptr_next[DEPTH_LOG2]) &&
                     (wr_ptr_next[DEPTH_LOG2-1:0] == rd_ptr_next[DEPTH_LOG2-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ready_reg  <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      ready_reg  <= !full_next;
      empty_reg  <= (wr_ptr_next == rd_ptr_next);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= in_data;
  end
endmodule

module axi_sync_channel_buffer #(
  parameter int ID_W          = 4,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int AW_DEPTH_LOG2 = 2,
  parameter int AR_DEPTH_LOG2 = 2,
  parameter int W_DEPTH_LOG2  = 4,
  parameter int R_DEPTH_LOG2  = 4,
  parameter int B_DEPTH_LOG2  = 4,
  parameter int MAX_WR_OUTST  = 4,
  parameter int MAX_RD_OUTST  = 4
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RSTN,
  axi_sync_channel_buffer_if.slave  s,
  axi_sync_channel_buffer_if.master m,
  output logic [4:0]               fifo_empty_flag,
  output logic [7:0]               wr_outst_cnt,
  output logic [7:0]               rd_outst_cnt
);
  localparam int AX_PW = ID_W + ADDR_W + 8 + 3 + 2;
  localparam int W_PW  = DATA_W + DATA_W / 8 + 1;
  localparam int B_PW  = ID_W + 2;
  localparam int R_PW  = ID_W + DATA_W + 2 + 1;

  logic aw_fifo_valid, ar_fifo_valid;
  logic aw_hold_reg, ar_hold_reg, aw_gate, ar_gate;
  logic aw_empty, w_empty, b_empty, ar_empty, r_empty;
  logic wr_inc, wr_dec, rd_inc, rd_dec;

  // Once VALID is up the gate stays open until the handshake, so VALID never retracts.
  assign aw_gate    = aw_hold_reg || (wr_outst_cnt < 8'(MAX_WR_OUTST));
  assign ar_gate    = ar_hold_reg || (rd_outst_cnt < 8'(MAX_RD_OUTST));
  assign m.aw_valid = aw_fifo_valid && aw_gate;
  assign m.ar_valid = ar_fifo_valid && ar_gate;

  assign wr_inc = m.aw_valid && m.aw_ready;
  assign wr_dec = m.b_valid && m.b_ready;
  assign rd_inc = m.ar_valid && m.ar_ready;
  assign rd_dec = m.r_valid && m.r_ready && m.r_payload[0];

  assign fifo_empty_flag = {r_empty, ar_empty, b_empty, w_empty, aw_empty};

  axi_sync_channel_buffer_fifo #(.WIDTH(AX_PW), .DEPTH_LOG2(AW_DEPTH_LOG2)) aw_fifo (
    .clk(BUS_CLK), .rst_n(BUS_RSTN),
    .in_valid(s.aw_valid), .in_data(s.aw_payload), .in_ready(s.aw_ready),
    .out_valid(aw_fifo_valid), .out_data(m.aw_payload), .out_ready(m.aw_ready && aw_gate),
    .empty(aw_empty)
  );

  axi_sync_channel_buffer_fifo #(.WIDTH(W_PW), .DEPTH_LOG2(W_DEPTH_LOG2)) w_fifo (
    .clk(BUS_CLK), .rst_n(BUS_RSTN),
    .in_valid(s.w_valid), .in_data(s.w_payload), .in_ready(s.w_ready),
    .out_valid(m.w_valid), .out_data(m.w_payload), .out_ready(m.w_ready),
    .empty(w_empty)
  );

  axi_sync_channel_buffer_fifo #(.WIDTH(B_PW), .DEPTH_LOG2(B_DEPTH_LOG2)) b_fifo (
    .clk(BUS_CLK), .rst_n(BUS_RSTN),
    .in_valid(m.b_valid), .in_data(m.b_payload), .in_ready(m.b_ready),
    .out_valid(s.b_valid), .out_data(s.b_payload), .out_ready(s.b_ready),
    .empty(b_empty)
  );

  axi_sync_channel_buffer_fifo #(.WIDTH(AX_PW), .DEPTH_LOG2(AR_DEPTH_LOG2)) ar_fifo (
    .clk(BUS_CLK), .rst_n(BUS_RSTN),
    .in_valid(s.ar_valid), .in_data(s.ar_payload), .in_ready(s.ar_ready),
    .out_valid(ar_fifo_valid), .out_data(m.ar_payload), .out_ready(m.ar_ready && ar_gate),
    .empty(ar_empty)
  );

  axi_sync_channel_buffer_fifo #(.WIDTH(R_PW), .DEPTH_LOG2(R_DEPTH_LOG2)) r_fifo (
    .clk(BUS_CLK), .rst_n(BUS_RSTN),
    .in_valid(m.r_valid), .in_data(m.r_payload), .in_ready(m.r_ready),
    .out_valid(s.r_valid), .out_data(s.r_payload), .out_ready(s.r_ready),
    .empty(r_empty)
  );

  always_ff @(posedge BUS_CLK or negedge BUS_RSTN) begin
    if (!BUS_RSTN) begin
      aw_hold_reg  <= 1'b0;
      ar_hold_reg  <= 1'b0;
      wr_outst_cnt <= 8'd0;
      rd_outst_cnt <= 8'd0;
    end else begin
      aw_hold_reg <= m.aw_valid && !m.aw_ready;
      ar_hold_reg <= m.ar_valid && !m.ar_ready;
      // A response with nothing outstanding is a protocol error; hold at zero.
      case ({wr_inc, wr_dec})
        2'b10:   wr_outst_cnt <= wr_outst_cnt + 8'd1;
        2'b01:   if (wr_outst_cnt != 8'd0) wr_outst_cnt <= wr_outst_cnt - 8'd1;
        default: wr_outst_cnt <= wr_outst_cnt;
      endcase
      case ({rd_inc, rd_dec})
        2'b10:   rd_outst_cnt <= rd_outst_cnt + 8'd1;
        2'b01:   if (rd_outst_cnt != 8'd0) rd_outst_cnt <= rd_outst_cnt - 8'd1;
        default: rd_outst_cnt <= rd_outst_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sync_channel_buffer.sv
// Randomized bench for axi_sync_channel_buffer: queue-based reference for ordering and
// scenario arithmetic for the outstanding counters.
module tb_axi_sync_channel_buffer;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32;
  localparam int AX_PW = ID_W + ADDR_W + 13;
  localparam int W_PW  = DATA_W + DATA_W / 8 + 1;
  localparam int B_PW  = ID_W + 2;
  localparam int R_PW  = ID_W + DATA_W + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] flags;
  logic [7:0] wr_cnt, rd_cnt;
  int         total = 0;
  int         bad = 0;

  axi_sync_channel_buffer_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();
  axi_sync_channel_buffer_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

  axi_sync_channel_buffer #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .W_DEPTH_LOG2(4),
    .MAX_WR_OUTST(2), .MAX_RD_OUTST(1)
  ) dut (
    .BUS_CLK(clk), .BUS_RSTN(rst_n), .s(s_if), .m(m_if),
    .fifo_empty_flag(flags), .wr_outst_cnt(wr_cnt), .rd_outst_cnt(rd_cnt)
  );

  always #5 clk = ~clk;

  // Handshake monitors on the falling edge: they record what the next rising edge transfers.
  logic [AX_PW-1:0] m_aw_q[$], m_ar_q[$];
  logic [W_PW-1:0]  m_w_q[$];
  logic [B_PW-1:0]  s_b_q[$];
  logic [R_PW-1:0]  s_r_q[$];
  int               s_w_acc = 0;

  always @(negedge clk) begin
    if (m_if.aw_valid && m_if.aw_ready) m_aw_q.push_back(m_if.aw_payload);
    if (m_if.ar_valid && m_if.ar_ready) m_ar_q.push_back(m_if.ar_payload);
    if (m_if.w_valid && m_if.w_ready)   m_w_q.push_back(m_if.w_payload);
    if (s_if.b_valid && s_if.b_ready)   s_b_q.push_back(s_if.b_payload);
    if (s_if.r_valid && s_if.r_ready)   s_r_q.push_back(s_if.r_payload);
    if (s_if.w_valid && s_if.w_ready)   s_w_acc = s_w_acc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({s_if.aw_ready, s_if.w_ready, s_if.ar_ready, m_if.b_ready, m_if.r_ready} !== 5'b0) begin
      bad++; $display("FAIL reset_ready: got %b expected 00000",
        {s_if.aw_ready, s_if.w_ready, s_if.ar_ready, m_if.b_ready, m_if.r_ready});
    end
    total++;
    if ({m_if.aw_valid, m_if.w_valid, m_if.ar_valid, s_if.b_valid, s_if.r_valid} !== 5'b0) begin
      bad++; $display("FAIL reset_valid: got %b expected 00000",
        {m_if.aw_valid, m_if.w_valid, m_if.ar_valid, s_if.b_valid, s_if.r_valid});
    end
    total++;
    if (flags !== 5'b11111) begin bad++; $display("FAIL reset_flags: got %b expected 11111", flags); end
    total++;
    if ({wr_cnt, rd_cnt} !== 16'd0) begin
      bad++; $display("FAIL reset_cnt: got wr=%0d rd=%0d expected 0/0", wr_cnt, rd_cnt);
    end
    rst_n = 1'b1;
    total++;
    if (s_if.w_ready !== 1'b0) begin bad++; $display("FAIL release_early: got %b expected 0", s_if.w_ready); end
    tick();
    total++;
    if ({s_if.aw_ready, s_if.w_ready, s_if.ar_ready} !== 3'b111) begin
      bad++; $display("FAIL release_ready: got %b expected 111", {s_if.aw_ready, s_if.w_ready, s_if.ar_ready});
    end
    $display("test_reset done");
  endtask

  task automatic test_w_fill();
    logic [W_PW-1:0] sent[$];
    int base_w, base_acc, n;
    base_w = m_w_q.size();
    base_acc = s_w_acc;
    m_if.w_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      s_if.w_valid = 1'b1;
      s_if.w_payload = W_PW'({$urandom(), $urandom()});
      sent.push_back(s_if.w_payload);
      tick();
    end
    s_if.w_valid = 1'b0;
    total++;
    if (s_w_acc - base_acc !== 16) begin bad++; $display("FAIL wfill_accepted: got %0d expected 16", s_w_acc - base_acc); end
    total++;
    if (s_if.w_ready !== 1'b0) begin bad++; $display("FAIL wfill_ready: got %b expected 0", s_if.w_ready); end
    total++;
    if (flags[1] !== 1'b0) begin bad++; $display("FAIL wfill_flag_full: got %b expected 0", flags[1]); end
    for (int c = 0; c < 300 && (m_w_q.size() - base_w) < 16; c++) begin
      m_if.w_ready = 1'($urandom_range(0, 1));
      tick();
    end
    m_if.w_ready = 1'b1;
    repeat (3) tick();
    n = m_w_q.size() - base_w;
    total++;
    if (n !== 16) begin bad++; $display("FAIL wfill_out_count: got %0d expected 16", n); end
    for (int i = 0; i < 16 && i < n; i++) begin
      total++;
      if (m_w_q[base_w + i] !== sent[i]) begin
        bad++; $display("FAIL wfill_beat%0d: got %h expected %h", i, m_w_q[base_w + i], sent[i]);
      end
    end
    total++;
    if (flags[1] !== 1'b1) begin bad++; $display("FAIL wfill_flag_empty: got %b expected 1", flags[1]); end
    $display("test_w_fill done: %0d beats out", n);
  endtask

  task automatic test_limiter();
    logic [AX_PW-1:0] sent[$];
    logic [B_PW-1:0]  bexp;
    int base_aw, base_b;
    base_aw = m_aw_q.size();
    base_b = s_b_q.size();
    m_if.aw_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_if.aw_valid = 1'b1;
      s_if.aw_payload = AX_PW'({$urandom(), $urandom()});
      sent.push_back(s_if.aw_payload);
      tick();
    end
    s_if.aw_valid = 1'b0;
    repeat (6) tick();
    total++;
    if (m_aw_q.size() - base_aw !== 2) begin bad++; $display("FAIL lim_issued2: got %0d expected 2", m_aw_q.size() - base_aw); end
    total++;
    if (wr_cnt !== 8'd2) begin bad++; $display("FAIL lim_cnt2: got %0d expected 2", wr_cnt); end
    total++;
    if (flags[0] !== 1'b0) begin bad++; $display("FAIL lim_aw_held: got %b expected 0", flags[0]); end
    m_if.b_valid = 1'b1;
    m_if.b_payload = B_PW'($urandom());
    bexp = m_if.b_payload;
    tick();
    m_if.b_valid = 1'b0;
    repeat (4) tick();
    total++;
    if (m_aw_q.size() - base_aw !== 3) begin bad++; $display("FAIL lim_issued3: got %0d expected 3", m_aw_q.size() - base_aw); end
    for (int i = 0; i < 3 && i < m_aw_q.size() - base_aw; i++) begin
      total++;
      if (m_aw_q[base_aw + i] !== sent[i]) begin
        bad++; $display("FAIL lim_aw%0d: got %h expected %h", i, m_aw_q[base_aw + i], sent[i]);
      end
    end
    total++;
    if (wr_cnt !== 8'd2) begin bad++; $display("FAIL lim_cnt_after_b: got %0d expected 2", wr_cnt); end
    total++;
    if (s_b_q.size() - base_b !== 1 || s_b_q[s_b_q.size() - 1] !== bexp) begin
      bad++; $display("FAIL lim_b_out: got n=%0d last=%h expected n=1 %h", s_b_q.size() - base_b,
        s_b_q[s_b_q.size() - 1], bexp);
    end
    $display("test_limiter done: wr_cnt=%0d", wr_cnt);
  endtask

  task automatic test_read();
    logic [AX_PW-1:0] ars[$];
    logic [R_PW-1:0]  rexp[$];
    logic [AX_PW-1:0] ax;
    logic [R_PW-1:0]  rb;
    int base_ar, base_r;
    base_ar = m_ar_q.size();
    base_r = s_r_q.size();
    m_if.ar_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ax = AX_PW'({$urandom(), $urandom()});
      ax[12:5] = 8'd3;
      s_if.ar_valid = 1'b1;
      s_if.ar_payload = ax;
      ars.push_back(ax);
      tick();
    end
    s_if.ar_valid = 1'b0;
    repeat (5) tick();
    total++;
    if (m_ar_q.size() - base_ar !== 1 || rd_cnt !== 8'd1) begin
      bad++; $display("FAIL rd_first: got issued=%0d cnt=%0d expected 1/1", m_ar_q.size() - base_ar, rd_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      rb = R_PW'({$urandom(), $urandom()});
      rb[0] = (k == 3);
      m_if.r_valid = 1'b1;
      m_if.r_payload = rb;
      rexp.push_back(rb);
      tick();
      if (k < 3) begin
        total++;
        if (m_ar_q.size() - base_ar !== 1 || rd_cnt !== 8'd1) begin
          bad++; $display("FAIL rd_hold_beat%0d: got issued=%0d cnt=%0d expected 1/1", k, m_ar_q.size() - base_ar, rd_cnt);
        end
      end
    end
    m_if.r_valid = 1'b0;
    total++;
    if (rd_cnt !== 8'd0) begin bad++; $display("FAIL rd_cnt_drop: got %0d expected 0", rd_cnt); end
    tick();
    total++;
    if (m_ar_q.size() - base_ar !== 2 || rd_cnt !== 8'd1) begin
      bad++; $display("FAIL rd_second: got issued=%0d cnt=%0d expected 2/1", m_ar_q.size() - base_ar, rd_cnt);
    end
    for (int i = 0; i < 2 && i < m_ar_q.size() - base_ar; i++) begin
      total++;
      if (m_ar_q[base_ar + i] !== ars[i]) begin
        bad++; $display("FAIL rd_ar%0d: got %h expected %h", i, m_ar_q[base_ar + i], ars[i]);
      end
    end
    rb = R_PW'({$urandom(), $urandom()});
    rb[0] = 1'b1;
    m_if.r_valid = 1'b1;
    m_if.r_payload = rb;
    rexp.push_back(rb);
    tick();
    m_if.r_valid = 1'b0;
    repeat (4) tick();
    total++;
    if (rd_cnt !== 8'd0) begin bad++; $display("FAIL rd_cnt_closed: got %0d expected 0", rd_cnt); end
    total++;
    if (s_r_q.size() - base_r !== 5) begin bad++; $display("FAIL rd_r_count: got %0d expected 5", s_r_q.size() - base_r); end
    for (int i = 0; i < 5 && i < s_r_q.size() - base_r; i++) begin
      total++;
      if (s_r_q[base_r + i] !== rexp[i]) begin
        bad++; $display("FAIL rd_r%0d: got %h expected %h", i, s_r_q[base_r + i], rexp[i]);
      end
    end
    $display("test_read done: rd_cnt=%0d", rd_cnt);
  endtask

  task automatic test_simultaneous();
    logic [R_PW-1:0] rb;
    int base_aw, base_r;
    // Retire the two outstanding writes, then open one fresh write.
    m_if.b_valid = 1'b1;
    m_if.b_payload = B_PW'($urandom());
    repeat (2) tick();
    m_if.b_valid = 1'b0;
    s_if.aw_valid = 1'b1;
    s_if.aw_payload = AX_PW'({$urandom(), $urandom()});
    tick();
    s_if.aw_valid = 1'b0;
    repeat (4) tick();
    total++;
    if (wr_cnt !== 8'd1) begin bad++; $display("FAIL sim_setup_cnt: got %0d expected 1", wr_cnt); end
    base_aw = m_aw_q.size();
    total++;
    if (m_if.aw_valid !== 1'b0) begin bad++; $display("FAIL sim_aw_idle: got %b expected 0", m_if.aw_valid); end
    s_if.aw_valid = 1'b1;
    s_if.aw_payload = AX_PW'({$urandom(), $urandom()});
    tick();
    s_if.aw_valid = 1'b0;
    total++;
    if (m_if.aw_valid !== 1'b1) begin bad++; $display("FAIL sim_aw_latency: got %b expected 1", m_if.aw_valid); end
    m_if.b_valid = 1'b1;
    m_if.b_payload = B_PW'($urandom());
    tick();
    m_if.b_valid = 1'b0;
    total++;
    if (wr_cnt !== 8'd1 || m_aw_q.size() - base_aw !== 1) begin
      bad++; $display("FAIL sim_cnt_same: got cnt=%0d issued=%0d expected 1/1", wr_cnt, m_aw_q.size() - base_aw);
    end
    // R beat with RLAST while nothing is outstanding: count must stay at zero.
    base_r = s_r_q.size();
    s_if.r_ready = 1'b0;
    rb = R_PW'({$urandom(), $urandom()});
    rb[0] = 1'b1;
    m_if.r_valid = 1'b1;
    m_if.r_payload = rb;
    tick();
    m_if.r_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (s_if.r_valid !== 1'b1 || s_if.r_payload !== rb) begin
        bad++; $display("FAIL sim_r_hold%0d: got v=%b %h expected v=1 %h", c, s_if.r_valid, s_if.r_payload, rb);
      end
    end
    total++;
    if (rd_cnt !== 8'd0) begin bad++; $display("FAIL sim_rd_saturate: got %0d expected 0", rd_cnt); end
    s_if.r_ready = 1'b1;
    repeat (2) tick();
    total++;
    if (s_r_q.size() - base_r !== 1 || s_r_q[s_r_q.size() - 1] !== rb) begin
      bad++; $display("FAIL sim_r_release: got n=%0d %h expected n=1 %h", s_r_q.size() - base_r, s_r_q[s_r_q.size() - 1], rb);
    end
    $display("test_simultaneous done: wr_cnt=%0d", wr_cnt);
  endtask

  task automatic test_back_to_back();
    logic [R_PW-1:0] rexp[$];
    int base_r, idx, n;
    base_r = s_r_q.size();
    for (int i = 0; i < 24; i++) begin
      rexp.push_back(R_PW'({$urandom(), $urandom()}) & ~R_PW'(1));
    end
    idx = 0;
    for (int c = 0; c < 600 && idx < 24; c++) begin
      m_if.r_valid = 1'($urandom_range(0, 1));
      m_if.r_payload = rexp[idx];
      s_if.r_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (m_if.r_valid && m_if.r_ready) idx++;
      tick();
    end
    m_if.r_valid = 1'b0;
    s_if.r_ready = 1'b1;
    repeat (30) tick();
    n = s_r_q.size() - base_r;
    total++;
    if (n !== 24) begin bad++; $display("FAIL b2b_count: got %0d expected 24", n); end
    for (int i = 0; i < 24 && i < n; i++) begin
      total++;
      if (s_r_q[base_r + i] !== rexp[i]) begin
        bad++; $display("FAIL b2b_r%0d: got %h expected %h", i, s_r_q[base_r + i], rexp[i]);
      end
    end
    $display("test_back_to_back done: %0d beats", n);
  endtask

  task automatic test_mid_reset();
    int base_w;
    base_w = m_w_q.size();
    m_if.w_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_if.w_valid = 1'b1;
      s_if.w_payload = W_PW'({$urandom(), $urandom()});
      tick();
    end
    total++;
    if (flags[1] !== 1'b0) begin bad++; $display("FAIL mrst_buffered: got %b expected 0", flags[1]); end
    rst_n = 1'b0;
    tick();
    total++;
    if (flags !== 5'b11111 || s_if.w_ready !== 1'b0 || wr_cnt !== 8'd0) begin
      bad++; $display("FAIL mrst_in_reset: got flags=%b wready=%b cnt=%0d expected 11111/0/0", flags, s_if.w_ready, wr_cnt);
    end
    s_if.w_valid = 1'b0;
    rst_n = 1'b1;
    m_if.w_ready = 1'b1;
    repeat (10) tick();
    total++;
    if (m_w_q.size() - base_w !== 0) begin bad++; $display("FAIL mrst_no_replay: got %0d expected 0", m_w_q.size() - base_w); end
    total++;
    if (flags !== 5'b11111) begin bad++; $display("FAIL mrst_flags: got %b expected 11111", flags); end
    $display("test_mid_reset done");
  endtask

  initial begin
    s_if.aw_valid = 1'b0; s_if.aw_payload = '0;
    s_if.w_valid  = 1'b0; s_if.w_payload  = '0;
    s_if.ar_valid = 1'b0; s_if.ar_payload = '0;
    s_if.b_ready  = 1'b1; s_if.r_ready    = 1'b1;
    m_if.aw_ready = 1'b1; m_if.w_ready    = 1'b1; m_if.ar_ready = 1'b1;
    m_if.b_valid  = 1'b0; m_if.b_payload  = '0;
    m_if.r_valid  = 1'b0; m_if.r_payload  = '0;
    test_reset();
    test_w_fill();
    test_limiter();
    test_read();
    test_simultaneous();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
